mp_regfile: RTL and testbench

Parametrised multi-port register file with write-through bypass and a per-register pending (scoreboard) bit. It is the successor to the single-write, dual-read integer register file. It serves a datapath that retires up to NWRITE results per cycle and issues instructions whose destinations must be marked pending until written back. Register 0 can optionally be hardwired to zero.

---
 rtl/mp_regfile.sv | 118 +++++++++++
 tb/tb_mp_regfile.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_regfile.sv
// Multi-port register file with same-cycle write bypass and a per-register
// pending (scoreboard) bit set on issue and cleared on writeback.
module mp_regfile #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NWRITE-1:0]       we,
  input  logic [NWRITE*AW-1:0]    waddr,
  input  logic [NWRITE*WIDTH-1:0] wdata,
  input  logic [NREAD*AW-1:0]     raddr,
  output logic [NREAD*WIDTH-1:0]  rdata,
  output logic [NREAD-1:0]        rbusy,
  input  logic                    issue_valid,
  input  logic [AW-1:0]           issue_dest,
  output logic [DEPTH-1:0]        busy_vec
);

  logic [WIDTH-1:0]  data_r [DEPTH];
  logic [DEPTH-1:0]  busy_r;
  logic [DEPTH-1:0]  busy_next_s;
  logic [NWRITE-1:0] wr_live_s;

  // A register is "live" if it exists and is not the hardwired zero register;
  // only live registers accept writes, bypass, go pending or read from storage.
  function automatic logic reg_live(input logic [AW-1:0] a);
    logic in_range;
    logic is_zero;
    in_range = (32'(a) < 32'(DEPTH));
    is_zero  = (ZERO_REG != 32'sd0) && (a == {AW{1'b0}});
    return in_range && !is_zero;
  endfunction

  // Qualify each write port against the live-register rule.
  always_comb begin
    wr_live_s = {NWRITE{1'b0}};
    for (int k = 0; k < NWRITE; k++) begin
      wr_live_s[k] = we[k] && reg_live(waddr[k*AW +: AW]);
    end
  end

  // Next pending bits: writeback clears, issue sets afterwards so it wins.
  always_comb begin
    busy_next_s = busy_r;
    for (int k = 0; k < NWRITE; k++) begin
      if (wr_live_s[k]) begin
        busy_next_s[waddr[k*AW +: AW]] = 1'b0;
      end else begin
        busy_next_s = busy_next_s;
      end
    end
    if (issue_valid && reg_live(issue_dest)) begin
      busy_next_s[issue_dest] = 1'b1;
    end else begin
      busy_next_s = busy_next_s;
    end
  end

  // Storage and scoreboard update; later ports overwrite earlier ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        data_r[r] <= {WIDTH{1'b0}};
      end
      busy_r <= {DEPTH{1'b0}};
    end else begin
      for (int k = 0; k < NWRITE; k++) begin
        if (wr_live_s[k]) begin
          data_r[waddr[k*AW +: AW]] <= wdata[k*WIDTH +: WIDTH];
        end
      end
      busy_r <= busy_next_s;
    end
  end

  // Read ports: bypass from the highest-index matching write, else storage.
  always_comb begin : read_mux
    logic [AW-1:0]    ra;
    logic             hit;
    logic [WIDTH-1:0] byp;
    ra    = {AW{1'b0}};
    hit   = 1'b0;
    byp   = {WIDTH{1'b0}};
    rdata = {(NREAD*WIDTH){1'b0}};
    rbusy = {NREAD{1'b0}};
    for (int j = 0; j < NREAD; j++) begin
      ra  = raddr[j*AW +: AW];
      hit = 1'b0;
      byp = {WIDTH{1'b0}};
      for (int k = 0; k < NWRITE; k++) begin
        if (wr_live_s[k] && (waddr[k*AW +: AW] == ra)) begin
          hit = 1'b1;
          byp = wdata[k*WIDTH +: WIDTH];
        end else begin
          hit = hit;
        end
      end
      if (!reg_live(ra)) begin
        rdata[j*WIDTH +: WIDTH] = {WIDTH{1'b0}};
        rbusy[j]                = 1'b0;
      end else if (hit) begin
        rdata[j*WIDTH +: WIDTH] = byp;
        rbusy[j]                = 1'b0;
      end else begin
        rdata[j*WIDTH +: WIDTH] = data_r[ra];
        rbusy[j]                = busy_r[ra];
      end
    end
  end

  assign busy_vec = busy_r;

endmodule

// File: tb/tb_mp_regfile.sv
// Self-checking bench for mp_regfile: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_mp_regfile;

  logic        clk;
  logic        rst;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        issue_valid;
  logic [4:0]  issue_dest;
  logic [31:0] busy_vec;

  int n_cmp;
  int n_bad;

  // reference model state
  logic [31:0] m_mem [32];
  logic [31:0] m_busy;

  mp_regfile dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] wa(input int k);
    return waddr[k*5 +: 5];
  endfunction

  function automatic logic [31:0] wd(input int k);
    return wdata[k*32 +: 32];
  endfunction

  // Expected read value from the model: r0 is zero, latest-port bypass, else memory.
  function automatic logic [31:0] exp_rdata(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    for (int k = 1; k >= 0; k--)
      if (we[k] && wa(k) == a) return wd(k);
    return m_mem[a];
  endfunction

  function automatic logic exp_rbusy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    for (int k = 0; k < 2; k++)
      if (we[k] && wa(k) == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic idle();
    we = 2'b00; waddr = 10'd0; wdata = 64'd0; raddr = 10'd0;
    issue_valid = 1'b0; issue_dest = 5'd0;
  endtask

  task automatic set_write(input int k, input logic [4:0] a, input logic [31:0] d);
    we[k] = 1'b1; waddr[k*5 +: 5] = a; wdata[k*32 +: 32] = d;
  endtask

  task automatic set_read(input int j, input logic [4:0] a);
    raddr[j*5 +: 5] = a;
  endtask

  // Advance one clock, apply the specification's edge rules to the model,
  // then step off the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 32; r++) m_mem[r] = 32'd0;
      m_busy = 32'd0;
    end else begin
      for (int k = 0; k < 2; k++)
        if (we[k] && wa(k) != 5'd0) begin
          m_mem[wa(k)] = wd(k);
          m_busy[wa(k)] = 1'b0;
        end
      if (issue_valid && issue_dest != 5'd0) m_busy[issue_dest] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1;
    tick(); tick();
    rst = 1'b0; #1;
    n_cmp++;
    if (busy_vec !== 32'd0) begin
      n_bad++; $display("FAIL reset_busy_vec got=%h want=%h", busy_vec, 32'd0);
    end
    for (int r = 0; r < 32; r += 2) begin
      set_read(0, 5'(r)); set_read(1, 5'(r + 1)); #1;
      n_cmp++;
      if (rdata !== 64'd0 || rbusy !== 2'b00) begin
        n_bad++; $display("FAIL reset_read r=%0d got=%h/%b want=0/00", r, rdata, rbusy);
      end
    end
  endtask

  task automatic test_zero_reg();
    idle(); set_write(0, 5'd0, 32'hDEADBEEF); set_read(0, 5'd0);
    issue_valid = 1'b1; issue_dest = 5'd0; #1;
    n_cmp++;
    if (rdata[31:0] !== 32'd0) begin
      n_bad++; $display("FAIL zero_bypass got=%h want=%h", rdata[31:0], 32'd0);
    end
    tick(); idle(); set_read(0, 5'd0); #1;
    n_cmp++;
    if (rdata[31:0] !== 32'd0 || busy_vec !== 32'd0 || rbusy[0] !== 1'b0) begin
      n_bad++; $display("FAIL zero_store got=%h/%h want=0/0", rdata[31:0], busy_vec);
    end
  endtask

  task automatic test_bypass_priority();
    idle(); set_write(0, 5'd5, 32'h11111111); set_write(1, 5'd5, 32'h22222222);
    set_read(0, 5'd5); #1;
    n_cmp++;
    if (rdata[31:0] !== 32'h22222222) begin
      n_bad++; $display("FAIL bypass_prio got=%h want=%h", rdata[31:0], 32'h22222222);
    end
    tick(); idle(); set_read(0, 5'd5); #1;
    n_cmp++;
    if (rdata[31:0] !== 32'h22222222) begin
      n_bad++; $display("FAIL store_prio got=%h want=%h", rdata[31:0], 32'h22222222);
    end
  endtask

  task automatic test_dual_write();
    idle(); set_write(0, 5'd3, 32'hA5A5A5A5); set_write(1, 5'd4, 32'h5A5A5A5A);
    tick(); idle(); set_read(0, 5'd3); set_read(1, 5'd4); #1;
    n_cmp++;
    if (rdata !== {32'h5A5A5A5A, 32'hA5A5A5A5}) begin
      n_bad++; $display("FAIL dual_write got=%h want=%h", rdata, {32'h5A5A5A5A, 32'hA5A5A5A5});
    end
    set_read(0, 5'd4); set_read(1, 5'd3); #1;
    n_cmp++;
    if (rdata !== {32'hA5A5A5A5, 32'h5A5A5A5A}) begin
      n_bad++; $display("FAIL dual_swap got=%h want=%h", rdata, {32'hA5A5A5A5, 32'h5A5A5A5A});
    end
  endtask

  task automatic test_scoreboard();
    idle(); issue_valid = 1'b1; issue_dest = 5'd7;
    tick();
    for (int c = 1; c <= 2; c++) begin
      idle(); set_read(0, 5'd7); #1;
      n_cmp++;
      if (busy_vec[7] !== 1'b1 || rbusy[0] !== 1'b1) begin
        n_bad++; $display("FAIL sb_pending t+%0d got=%b/%b want=1/1", c, busy_vec[7], rbusy[0]);
      end
      tick();
    end
    idle(); set_read(0, 5'd7); set_write(0, 5'd7, 32'h77); #1;
    n_cmp++;
    if (rbusy[0] !== 1'b0 || rdata[31:0] !== 32'h77 || busy_vec[7] !== 1'b1) begin
      n_bad++; $display("FAIL sb_writeback got=%b/%h/%b want=0/77/1", rbusy[0], rdata[31:0], busy_vec[7]);
    end
    tick(); idle(); set_read(0, 5'd7); #1;
    n_cmp++;
    if (busy_vec[7] !== 1'b0 || rdata[31:0] !== 32'h77) begin
      n_bad++; $display("FAIL sb_retired got=%b/%h want=0/77", busy_vec[7], rdata[31:0]);
    end
  endtask

  task automatic test_collision();
    idle(); issue_valid = 1'b1; issue_dest = 5'd9;
    tick();
    idle(); issue_valid = 1'b1; issue_dest = 5'd9; set_write(0, 5'd9, 32'h99);
    tick(); idle(); set_read(0, 5'd9); #1;
    n_cmp++;
    if (busy_vec[9] !== 1'b1 || rbusy[0] !== 1'b1 || rdata[31:0] !== 32'h99) begin
      n_bad++; $display("FAIL collision got=%b/%b/%h want=1/1/99", busy_vec[9], rbusy[0], rdata[31:0]);
    end
  endtask

  task automatic test_reset_mid();
    idle(); set_write(0, 5'd2, 32'h1234); tick();
    idle(); issue_valid = 1'b1; issue_dest = 5'd2; tick();
    idle(); issue_valid = 1'b1; issue_dest = 5'd8; tick();
    idle(); #1;
    n_cmp++;
    if (busy_vec[2] !== 1'b1 || busy_vec[8] !== 1'b1) begin
      n_bad++; $display("FAIL rmid_setup got=%b%b want=11", busy_vec[2], busy_vec[8]);
    end
    rst = 1'b1; set_write(0, 5'd8, 32'hFFFF); issue_valid = 1'b1; issue_dest = 5'd5;
    tick();
    rst = 1'b0; idle(); set_read(0, 5'd2); set_read(1, 5'd8); #1;
    n_cmp++;
    if (busy_vec !== 32'd0 || rdata !== 64'd0) begin
      n_bad++; $display("FAIL rmid_clear got=%h/%h want=0/0", busy_vec, rdata);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      we = 2'($urandom_range(0, 3));
      waddr = 10'($urandom);
      wdata = {$urandom, $urandom};
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_dest = 5'($urandom);
      // bias reads toward recently written/issued registers to exercise bypass
      raddr = ($urandom_range(0, 1) != 0) ? {issue_dest, waddr[4:0]} : {waddr[9:5], 5'($urandom)};
      #1;
      for (int j = 0; j < 2; j++) begin
        n_cmp++;
        if (rdata[j*32 +: 32] !== exp_rdata(raddr[j*5 +: 5]) || rbusy[j] !== exp_rbusy(raddr[j*5 +: 5])) begin
          n_bad++;
          $display("FAIL rand_read c=%0d j=%0d a=%0d got=%h/%b want=%h/%b", c, j, raddr[j*5 +: 5],
                   rdata[j*32 +: 32], rbusy[j], exp_rdata(raddr[j*5 +: 5]), exp_rbusy(raddr[j*5 +: 5]));
        end
      end
      n_cmp++;
      if (busy_vec !== m_busy) begin
        n_bad++; $display("FAIL rand_busy c=%0d got=%h want=%h", c, busy_vec, m_busy);
      end
      tick();
    end
    rst = 1'b0; idle();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    m_busy = 32'd0;
    for (int r = 0; r < 32; r++) m_mem[r] = 32'd0;
    rst = 1'b1; idle();
    @(negedge clk);
    test_reset();
    test_zero_reg();
    test_bypass_priority();
    test_dual_write();
    test_scoreboard();
    test_collision();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
